bcd_seg_display: RTL and testbench



---
 rtl/bcd_seg_display.sv | 218 +++++++++++++++++++++
 tb/tb_bcd_seg_display.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_display.sv
// bcd_seg_display
//   Binary value in, multiplexed common-anode 7-segment drive out, all on
//   one clock. A sequential double-dabble converter (start/busy/done
//   handshake) produces a registered BCD result plus an overflow flag. An
//   internal prescaler scans the digits. The display always shows the last
//   completed result.
//
//   Build option: define BCD_SEG_BLANK_EN to blank leading zeros on digits
//   above digit 0. Overflow dashes take priority over blanking.
//
// Parameters
//   BIN_W        binary input width (1..32)
//   DIGITS       BCD digits / anodes (1..8)
//   REFRESH_DIV  clk cycles each digit stays lit (>=2)
//
// Ports
//   clk       system clock
//   rst_n     synchronous active-low reset
//   bin_in    binary value, sampled only on an accepted start
//   start     conversion request, honoured only while idle
//   busy      conversion in progress
//   done      one-cycle pulse, high the cycle bcd_out/overflow update
//   bcd_out   registered BCD result, digit 0 in [3:0]
//   overflow  registered, last converted value >= 10**DIGITS
//   anode     active-low one-hot digit enable
//   cathode   active-low segments, [0]=a .. [6]=g
module bcd_seg_display #(
    parameter int BIN_W       = 12,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            cathode
);
    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] ITERS   = CNT_W'(BIN_W);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t             state_q, state_d;
    logic               load_en, shift_en, fin_en;

    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [SW-1:0]      scratch_q, scratch_d;
    logic [SW-1:0]      adj;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]      bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0]  anode_q, anode_d;
    logic [6:0]         cathode_q, cathode_d;
    logic [3:0]         digit_arr [DIGITS];
    logic [3:0]         sel_digit;

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            // cnt_q still holds the pre-decrement count: 1 means this is
            // the last of the BIN_W shifts.
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        load_en  = (state_q == IDLE) && start;
        shift_en = (state_q == SHIFT);
        fin_en   = (state_q == FIN);
    end

    // ------------------------------------------------------------------
    // Double-dabble datapath
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                scratch_q[4*gi +: 4] + 4'd3 :
                                scratch_q[4*gi +: 4];
    end

    always_comb begin
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = fin_en;
        if (load_en) begin
            shreg_d   = bin_in;
            scratch_d = '0;
            ovf_d     = 1'b0;
            cnt_d     = ITERS;
        end else if (shift_en) begin
            // The bit leaving the top nibble is exactly "value no longer
            // fits in DIGITS"; once set it stays set for this conversion.
            scratch_d = {adj[SW-2:0], shreg_q[BIN_W-1]};
            shreg_d   = shreg_q << 1;
            ovf_d     = ovf_q | adj[SW-1];
            cnt_d     = cnt_q - CNT_W'(1);
        end else if (fin_en) begin
            bcd_d      = scratch_q;
            overflow_d = ovf_q;
        end
    end

    // ------------------------------------------------------------------
    // Refresh scan and segment decode
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        assign digit_arr[gi] = bcd_d[4*gi +: 4];
    end

`ifdef BCD_SEG_BLANK_EN
    logic [DIGITS-1:0] upper_zero;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        assign upper_zero[gi] = ~|bcd_d[SW-1:4*gi];
    end
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_MAX)
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        anode_d   = ~(DIGITS'(1) << idx_d);
        sel_digit = digit_arr[idx_d];
        // Decoded from the next-state result so the segments always match
        // the bcd_out/overflow value visible in the same cycle.
        if (overflow_d)
            cathode_d = 7'b0111111;
`ifdef BCD_SEG_BLANK_EN
        else if ((idx_d != '0) && upper_zero[idx_d])
            cathode_d = 7'b1111111;
`endif
        else
            cathode_d = seg7(sel_digit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            pre_q      <= '0;
            idx_q      <= '0;
            anode_q    <= ~DIGITS'(1);
            cathode_q  <= 7'b1000000;
        end else begin
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            anode_q    <= anode_d;
            cathode_q  <= cathode_d;
        end
    end

    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;
    assign anode    = anode_q;
    assign cathode  = cathode_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Testbench for bcd_seg_display (BIN_W=16, DIGITS=4, REFRESH_DIV=4).
// A value-level model (countdown to result, value mod 10**DIGITS, scan
// index from cycles since reset) is compared against the DUT every cycle;
// directed sections pin the model with hand-computed literals.
module tb_bcd_seg_display;
    localparam int BW    = 16;
    localparam int DG    = 4;
    localparam int RD    = 4;
    localparam int LIMIT = 10000;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [BW-1:0] bin_in = '0;
    logic          start  = 1'b0;
    logic          busy, done, overflow;
    logic [4*DG-1:0] bcd_out;
    logic [DG-1:0] anode;
    logic [6:0]    cathode;

    int n_pass  = 0;
    int n_total = 0;

    bcd_seg_display #(.BIN_W(BW), .DIGITS(DG), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .anode    (anode),
        .cathode  (cathode)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, want, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit model_on  = 1'b0;
    int remaining = 0;     // cycles until the pending result appears
    int pend      = 0;
    int m_val     = 0;     // displayed value (already reduced mod 10**DG)
    bit m_ovf     = 1'b0;
    bit m_done    = 1'b0;
    int since_rst = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_on  = 1'b1;
            remaining = 0;
            m_val     = 0;
            m_ovf     = 1'b0;
            m_done    = 1'b0;
            since_rst = 0;
        end else begin
            since_rst++;
            m_done = 1'b0;
            if (remaining == 0) begin
                if (start) begin
                    remaining = BW + 1;
                    pend      = int'(bin_in);
                end
            end else begin
                remaining--;
                if (remaining == 0) begin
                    m_val  = pend % LIMIT;
                    m_ovf  = (pend >= LIMIT);
                    m_done = 1'b1;
                end
            end
        end
    end

    function automatic logic [4*DG-1:0] to_bcd(input int v);
        logic [4*DG-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_cathode(input int v, input bit ovf, input int idx);
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (ovf) return 7'b0111111;
`ifdef BCD_SEG_BLANK_EN
        if (idx > 0 && (v / p) == 0) return 7'b1111111;
`endif
        return seg_tab[(v / p) % 10];
    endfunction

    always @(negedge clk) begin : cmp
        int idx;
        logic [DG-1:0] a_exp;
        if (model_on) begin
            idx = (since_rst / RD) % DG;
            a_exp = '1;
            a_exp[idx] = 1'b0;
            chk("busy",     busy,     (remaining != 0));
            chk("done",     done,     m_done);
            chk("bcd_out",  bcd_out,  to_bcd(m_val));
            chk("overflow", overflow, m_ovf);
            chk("anode",    anode,    a_exp);
            chk("cathode",  cathode,  exp_cathode(m_val, m_ovf, idx));
            if (done)
                $display("conversion: in=%0d bcd_out=%h overflow=%0b", pend, bcd_out, overflow);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one start and returns the edge count to done (-1 on timeout)
    // and the number of sampled cycles with busy high.
    task automatic convert(input int val, output int lat, output int busy_cycles);
        bin_in = BW'(val);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = BW'($urandom);
        lat = -1;
        busy_cycles = busy ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Waits (bounded) until digit 0 has just become the lit digit.
    task automatic align_scan();
        for (int g = 0; g < 2*RD*DG && (since_rst % (RD*DG)) != 0; g++)
            @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat, bc, dones;
        logic [3:0] an_tab [4];
        logic [6:0] c1234 [4];
        logic [6:0] c42 [4];
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        c1234[0] = 7'b0011001; c1234[1] = 7'b0110000; c1234[2] = 7'b0100100; c1234[3] = 7'b1111001;
        c42[0] = 7'b0100100; c42[1] = 7'b0011001;
`ifdef BCD_SEG_BLANK_EN
        c42[2] = 7'b1111111; c42[3] = 7'b1111111;
`else
        c42[2] = 7'b1000000; c42[3] = 7'b1000000;
`endif

        do_reset();
        chk("rst_busy",     busy,     1'b0);
        chk("rst_done",     done,     1'b0);
        chk("rst_bcd",      bcd_out,  16'h0000);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_anode",    anode,    4'b1110);
        chk("rst_cathode",  cathode,  7'b1000000);

        convert(4095, lat, bc);
        chk("lat_4095",  lat, 17);
        chk("busy_4095", bc,  17);
        chk("bcd_4095",  bcd_out,  16'h4095);
        chk("ovf_4095",  overflow, 1'b0);

        // 0 then 1 requested while still busy: only the first is converted
        bin_in = '0; start = 1'b1;
        @(negedge clk);
        bin_in = BW'(1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("b2b_dones", dones,   1);
        chk("b2b_bcd",   bcd_out, 16'h0000);

        // scan order and hold time
        convert(1234, lat, bc);
        chk("bcd_1234", bcd_out, 16'h1234);
        align_scan();
        for (int i = 0; i < 16; i++) begin
            chk("scan_anode",   anode,   an_tab[i/4]);
            chk("scan_cathode", cathode, c1234[i/4]);
            @(negedge clk);
        end

        // overflow boundary
        convert(10000, lat, bc);
        chk("lat_10000", lat, 17);
        chk("ovf_10000", overflow, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("dash_cathode", cathode, 7'b0111111);
            @(negedge clk);
        end
        convert(9999, lat, bc);
        chk("ovf_9999", overflow, 1'b0);
        chk("bcd_9999", bcd_out,  16'h9999);

        // leading zeros
        convert(42, lat, bc);
        chk("bcd_42", bcd_out, 16'h0042);
        align_scan();
        for (int i = 0; i < 16; i++) begin
            chk("blank_cathode", cathode, c42[i/4]);
            @(negedge clk);
        end

        // reset during SHIFT cycle 5
        bin_in = BW'(4095); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy",    busy,    1'b0);
        chk("midrst_done",    done,    1'b0);
        chk("midrst_bcd",     bcd_out, 16'h0000);
        chk("midrst_anode",   anode,   4'b1110);
        chk("midrst_cathode", cathode, 7'b1000000);
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_nodone", dones, 0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       bin_in = BW'($urandom);
                1:       bin_in = BW'($urandom_range(9990, 10010));
                2:       bin_in = BW'($urandom_range(0, 120));
                default: bin_in = ($urandom_range(0, 1) == 0) ? '0 : '1;
            endcase
            @(negedge clk);
        end
        rst_n = 1'b1;
        start = 1'b0;
        for (int n = 0; n < 25; n++) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
